// File: rtl/mod12_disp_pkg.sv
// mod12_disp_pkg: scan states, active-high segment codes (seg[6]=a .. seg[0]=g) and modulus.
package mod12_disp_pkg;
    typedef enum logic [1:0] {DIG0, BLK0, DIG1, BLK1} scan_state_t;
    localparam int MOD = 12;
    localparam logic [6:0] SEG_DASH = 7'b0000001;
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'b1111011, 7'b1111111, 7'b1110000, 7'b1011111, 7'b1011011,
        7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
    };
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: digit 0-9 or dash to active-high 7-segment pattern; blank for 10-15.
module seg7_decode
    import mod12_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dash,
    output logic [6:0] seg
);
    always_comb seg = dash ? SEG_DASH : (digit > 4'd9 ? 7'b0 : SEG_DIGIT[digit]);
endmodule

// File: rtl/mod12_seg_display.sv
// mod12_seg_display: two-digit scanned display of a mod-12 count; MOD12_SEG_DISPLAY_LZ_BLANK_EN blanks a leading zero.
module mod12_seg_display
    import mod12_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 1000,
    parameter int BLANK_CYC   = 4,
    parameter bit ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count_in,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       wrap_pulse,
    output logic       err
);
    localparam int PW = $clog2((REFRESH_DIV > BLANK_CYC ? REFRESH_DIV : BLANK_CYC) + 1);

    scan_state_t   state_q, state_d;
    logic [PW-1:0] presc_q, presc_d, last;
    logic [3:0]    count_q, count_d, prev_q, prev_d, dig_q, dig_d, units, tens;
    logic          prev_valid_q, prev_valid_d, wrap_q, wrap_d, err_q, err_d, dash_q, dash_d;
    logic [6:0]    seg_q, seg_d, seg_ah, seg_on;
    logic [1:0]    an_q, an_d, an_ah;
    logic          invalid, tens_lit;

    seg7_decode u_dec (.digit(dig_d), .dash(dash_d), .seg(seg_ah));

    always_comb begin
        count_d      = count_in;
        prev_d       = count_q;
        prev_valid_d = 1'b1;
        invalid      = count_q >= 4'(MOD);
        wrap_d       = prev_valid_q && prev_q == 4'd11 && count_q == 4'd0;
        err_d        = err_q || invalid;
        units        = count_q >= 4'd10 ? count_q - 4'd10 : count_q;
        tens         = (count_q >= 4'd10 && !invalid) ? 4'd1 : 4'd0;
        last         = (state_q == DIG0 || state_q == DIG1) ? PW'(REFRESH_DIV - 1) : PW'(BLANK_CYC - 1);
        state_d      = presc_q == last ? scan_state_t'(state_q + 2'd1) : state_q;
        presc_d      = presc_q == last ? '0 : presc_q + 1'b1;
        // Digit is captured only on a state change so a lit digit never changes mid-interval
        dig_d        = state_d != state_q ? (state_d == DIG1 ? tens : units) : dig_q;
        dash_d       = state_d != state_q ? invalid : dash_q;
`ifdef MOD12_SEG_DISPLAY_LZ_BLANK_EN
        tens_lit     = dash_d || dig_d != 4'd0;
`else
        tens_lit     = 1'b1;
`endif
        an_ah        = {state_d == DIG1 && tens_lit, state_d == DIG0};
        seg_on       = |an_ah ? seg_ah : 7'b0;
        seg_d        = ACTIVE_LOW ? ~seg_on : seg_on;
        an_d         = ACTIVE_LOW ? ~an_ah : an_ah;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
            err_q        <= 1'b0;
            state_q      <= BLK1;
            presc_q      <= '0;
            dig_q        <= '0;
            dash_q       <= 1'b0;
            seg_q        <= {7{ACTIVE_LOW}};
            an_q         <= {2{ACTIVE_LOW}};
        end else begin
            count_q      <= count_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            wrap_q       <= wrap_d;
            err_q        <= err_d;
            state_q      <= state_d;
            presc_q      <= presc_d;
            dig_q        <= dig_d;
            dash_q       <= dash_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign wrap_pulse = wrap_q;
    assign err        = err_q;
endmodule

// File: tb/tb_mod12_seg_display.sv
// tb_mod12_seg_display: table-driven scan checks plus wrap, error, latch and async-reset sequences.
module tb_mod12_seg_display;
`ifdef MOD12_SEG_DISPLAY_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] count_in = 4'd0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       wrap_pulse, err;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] cin;
        logic [6:0] u_seg;
        logic [6:0] t_seg;
        logic       t_lit;
    } vec_t;
    vec_t vecs [7];
    int seq [21] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 0, 0, 0, 11, 11, 13, 0, 0, 0};

    mod12_seg_display #(.REFRESH_DIV(4), .BLANK_CYC(2), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .count_in(count_in),
        .seg(seg), .an(an), .wrap_pulse(wrap_pulse), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [3:0] cin);
        @(negedge clk);
        rst = 1'b1;
        count_in = cin;
        #1;
        chk("rst_seg", 16'(seg), 16'h7f);
        chk("rst_an", 16'(an), 16'h3);
        chk("rst_wrap", 16'(wrap_pulse), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int p;
        int npulse;
        logic [6:0] es;
        logic [1:0] ea;
        vecs[0] = '{4'd7,  7'b0001111, 7'b0000001, !LZ};
        vecs[1] = '{4'd11, 7'b1001111, 7'b1001111, 1'b1};
        vecs[2] = '{4'd0,  7'b0000001, 7'b0000001, !LZ};
        vecs[3] = '{4'd10, 7'b0000001, 7'b1001111, 1'b1};
        vecs[4] = '{4'd5,  7'b0100100, 7'b0000001, !LZ};
        vecs[5] = '{4'd13, 7'b1111110, 7'b1111110, 1'b1};
        vecs[6] = '{4'd9,  7'b0000100, 7'b0000001, !LZ};

        for (int v = 0; v < 7; v++) begin
            do_reset(vecs[v].cin);
            for (int n = 1; n <= 14; n++) begin
                step;
                p = n < 2 ? -1 : (n - 2) % 12;
                if (p >= 0 && p < 4) begin
                    es = vecs[v].u_seg; ea = 2'b10;
                end else if (p >= 6 && p < 10 && vecs[v].t_lit) begin
                    es = vecs[v].t_seg; ea = 2'b01;
                end else begin
                    es = 7'h7f; ea = 2'b11;
                end
                chk($sformatf("v%0d_n%0d_seg", v, n), 16'(seg), 16'(es));
                chk($sformatf("v%0d_n%0d_an", v, n), 16'(an), 16'(ea));
                chk($sformatf("v%0d_n%0d_wrap", v, n), 16'(wrap_pulse), 16'h0);
                chk($sformatf("v%0d_n%0d_err", v, n), 16'(err), 16'(n >= 2 && vecs[v].cin >= 4'd12));
            end
        end

        do_reset(4'd0);
        npulse = 0;
        for (int i = 0; i < 21; i++) begin
            count_in = 4'(seq[i]);
            step;
            if (wrap_pulse) npulse++;
            chk($sformatf("wrap_e%0d", i + 1), 16'(wrap_pulse), 16'(i == 13));
        end
        chk("wrap_count", 16'(npulse), 16'd1);

        do_reset(4'd13);
        for (int n = 1; n <= 15; n++) begin
            count_in = n == 1 ? 4'd13 : 4'd5;
            step;
            chk($sformatf("err_n%0d", n), 16'(err), 16'(n >= 2));
            if (n == 3) begin
                chk("err_dash_seg", 16'(seg), 16'h7e);
                chk("err_dash_an", 16'(an), 16'h2);
            end
            if (n == 9) begin
                chk("err_tens_seg", 16'(seg), LZ ? 16'h7f : 16'h01);
                chk("err_tens_an", 16'(an), LZ ? 16'h3 : 16'h1);
            end
            if (n == 15) begin
                chk("err_five_seg", 16'(seg), 16'h24);
                chk("err_five_an", 16'(an), 16'h2);
            end
        end

        do_reset(4'd3);
        for (int n = 1; n <= 15; n++) begin
            count_in = n < 4 ? 4'd3 : 4'd4;
            step;
            if (n >= 3 && n <= 5) begin
                chk($sformatf("hold3_n%0d_seg", n), 16'(seg), 16'h06);
                chk($sformatf("hold3_n%0d_an", n), 16'(an), 16'h2);
            end
            if (n == 15) begin
                chk("next4_seg", 16'(seg), 16'h4c);
                chk("next4_an", 16'(an), 16'h2);
            end
        end

        do_reset(4'd7);
        repeat (9) step;
        chk("dig1_an", 16'(an), LZ ? 16'h3 : 16'h1);
        do_reset(4'd7);
        step;
        chk("rel_n1_an", 16'(an), 16'h3);
        step;
        chk("rel_n2_an", 16'(an), 16'h2);
        chk("rel_n2_seg", 16'(seg), 16'h0f);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mod12_seg_display.md
MOD12_SEG_DISPLAY -- requirements
Module: mod12_seg_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 1000, clk cycles each digit is lit.
REQ-002 SHALL have parameter BLANK_CYC, default 4, clk cycles all digits are dark between digits.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; 1 means seg and an outputs are active-low.
REQ-004 SHALL have clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have count_in, input, 4 bits: counter value from the upstream mod-12 counter.
REQ-007 SHALL have seg, output, 7 bits: segments, seg[6]=a through seg[0]=g.
REQ-008 SHALL have an, output, 2 bits: digit enables, an[0]=units, an[1]=tens.
REQ-009 SHALL have wrap_pulse, output, 1 bit: one-cycle pulse when the sampled count goes 11 -> 0.
REQ-010 SHALL have err, output, 1 bit: sticky flag, set when count_in >= 12.

Function
REQ-011 SHALL register count_in into count_q every cycle; all later logic uses count_q, giving 1-cycle latency.
REQ-012 SHALL split count_q into digits: count_q 10..11 gives tens=1 and units=count_q-10; count_q 0..9 gives tens=0 and units=count_q.
REQ-013 SHALL run a scan FSM through DIG0 -> BLK0 -> DIG1 -> BLK1 -> DIG0, driven by one prescaler.
REQ-014 SHALL hold each DIG state for REFRESH_DIV cycles and each BLK state for BLANK_CYC cycles; the prescaler clears on every state change.
REQ-015 SHALL latch the digit value on entry to DIG0/DIG1 and hold it until the state exits, so changes to count_q never alter a lit digit mid-interval.
REQ-016 SHALL drive an[0] active only in DIG0 and an[1] active only in DIG1; in BLK states an and seg are both inactive.
REQ-017 SHALL register seg and an, so they change together on the same edge.
REQ-018 SHALL, when count_q >= 12, display "--" on both digits (segment g only) and set err; err stays set until rst.
REQ-019 SHALL assert wrap_pulse for exactly one cycle when the previous count_q was 11 and the current count_q is 0.
REQ-020 SHALL not assert wrap_pulse for any other transition, including 11 -> 11, an invalid value -> 0, or the first sample after reset.
REQ-021 SHALL apply output polarity only at the output registers, using ACTIVE_LOW.

Reset
REQ-022 SHALL, while rst is high, force asynchronously: count_q=0, state=BLK1, prescaler=0, seg and an inactive (all 1s if ACTIVE_LOW=1), wrap_pulse=0, err=0, history register invalid.
REQ-023 SHALL, after rst deasserts, enter DIG0 after BLANK_CYC cycles.
REQ-024 SHALL, if rst asserts mid-scan, abandon the scan immediately and restart from REQ-022 state.

Configuration
REQ-025 SHALL compile leading-zero suppression when macro MOD12_SEG_DISPLAY_LZ_BLANK_EN is defined: when tens=0, an[1] stays inactive in DIG1.
REQ-026 SHALL, when MOD12_SEG_DISPLAY_LZ_BLANK_EN is not defined, light the tens digit showing "0" when tens=0.
REQ-027 SHALL display "--" on both digits for invalid values regardless of MOD12_SEG_DISPLAY_LZ_BLANK_EN.

Structure
REQ-028 SHALL place in package mod12_disp_pkg: the scan-state typedef (DIG0, BLK0, DIG1, BLK1), the 7-bit segment codes for 0-9 and dash, and the constant MOD=12.
REQ-029 SHALL use one combinational sub-module, seg7_decode, mapping a 4-bit digit plus a dash flag to active-high segments; polarity is applied in the parent.

Verification
REQ-030 SHALL cover: REFRESH_DIV=4, BLANK_CYC=2, count_in=7 held -> units lit 4 cycles showing 7 (active-low 7'b0001111), dark 2, tens lit 4 cycles showing "0" (or dark with MOD12_SEG_DISPLAY_LZ_BLANK_EN), period 12 cycles.
REQ-031 SHALL cover: count_in=11 -> both digits show "1" (active-low 7'b1001111).
REQ-032 SHALL cover: count_in sweeps 0..11 then 0 -> wrap_pulse high exactly once, 2 cycles after count_in goes 0 (1-cycle sample + 1-cycle registered history compare).
REQ-033 SHALL cover: count_in=13 for one cycle then 5 -> err=1 and stays 1; display shows "--" only while the sampled value is 13.
REQ-034 SHALL cover: count_in changes 3 -> 4 mid-DIG0 -> units keeps showing 3 until DIG0 exits; the next DIG0 shows 4.
REQ-035 SHALL cover: rst pulsed mid-DIG1 between clock edges -> seg/an inactive without waiting for a clock edge; DIG0 entered BLANK_CYC cycles after release.
